la_capture_ctrl: RTL and testbench

LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

---
 rtl/la_capture_if.sv | 32 +++
 rtl/la_capture_ctrl.sv | 131 +++++++++++++
 tb/tb_la_capture_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/la_capture_if.sv
// Control and decoder bundle for the logic-analyser capture controller.
// The master drives the software controls and decoder events; the slave is the controller.
interface la_capture_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              arm;
  logic              abort;
  logic              ack;
  logic [ADDR_W:0]   byte_limit;
  logic              start_det;
  logic              stop_det;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   byte_count;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic              wait_led;

  modport master (
    output arm, abort, ack, byte_limit, start_det, stop_det, byte_valid, byte_data,
    input  wr_en, wr_addr, wr_data, byte_count, busy, done, status, wait_led
  );

  modport slave (
    input  arm, abort, ack, byte_limit, start_det, stop_det, byte_valid, byte_data,
    output wr_en, wr_addr, wr_data, byte_count, busy, done, status, wait_led
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Capture controller: arms on request, waits for a bus START, streams decoded bytes into a
// buffer and closes the capture on STOP, buffer full or inactivity timeout.
module la_capture_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic         clk,
  input logic         rst,
  la_capture_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT);
  localparam logic [ADDR_W:0] FullDepth = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] StatStop    = 2'b00;
  localparam logic [1:0] StatFull    = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   limit_q, limit_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        status_q, status_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, done_q, wait_led_q;

  // Next-state decode; abort overrides every other input and drops any pending write.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    tmo_d     = tmo_q;
    status_d  = status_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.arm) begin
            state_d  = StArmed;
            count_d  = '0;
            tmo_d    = '0;
            status_d = StatStop;
            // A zero limit means the whole buffer.
            limit_d  = (bus.byte_limit == '0) ? FullDepth : bus.byte_limit;
          end
        end
        StArmed: begin
          if (bus.start_det) state_d = StCapture;
        end
        StCapture: begin
          if (bus.byte_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            wr_data_d = bus.byte_data;
            count_d   = count_q + (ADDR_W+1)'(1);
            tmo_d     = '0;
            // Full takes precedence over a coincident STOP.
            if (count_d == limit_q) begin
              state_d  = StDone;
              status_d = StatFull;
            end else if (bus.stop_det) begin
              state_d  = StDone;
              status_d = StatStop;
            end
          end else if (bus.stop_det) begin
            state_d  = StDone;
            status_d = StatStop;
          end else begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_d == TmoMax) begin
              state_d  = StDone;
              status_d = StatTimeout;
            end
          end
        end
        StDone: begin
          if (bus.ack) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs; status flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      limit_q    <= FullDepth;
      tmo_q      <= '0;
      status_q   <= StatStop;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_led_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      tmo_q      <= tmo_d;
      status_q   <= status_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= (state_d == StArmed) || (state_d == StCapture);
      done_q     <= (state_d == StDone);
      wait_led_q <= (state_d == StIdle) || (state_d == StArmed);
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.byte_count = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;
  assign bus.wait_led   = wait_led_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a write scoreboard.
module tb_la_capture_ctrl;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 20;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  sb[$];

  la_capture_if #(.ADDR_W(ADDR_W)) bus ();

  la_capture_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop an expected write for every wr_en seen mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      check("sb_has_entry", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic [ADDR_W-1:0] a, input bit exp_wr);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    if (exp_wr) sb.push_back('{addr: a, data: d});
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [ADDR_W:0] lim);
    bus.arm = 1'b1;
    bus.byte_limit = lim;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic do_start();
    bus.start_det = 1'b1;
    tick();
    bus.start_det = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, "_count"}, 32'(bus.byte_count), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_status"}, 32'(bus.status), 32'd0);
    check({tag, "_wait_led"}, 32'(bus.wait_led), 32'd1);
  endtask

  initial begin
    bus.arm = 0; bus.abort = 0; bus.ack = 0; bus.byte_limit = '0;
    bus.start_det = 0; bus.stop_det = 0; bus.byte_valid = 0; bus.byte_data = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Two bytes then STOP; bytes in ARMED and arm during CAPTURE are ignored
    do_arm(5'd16);
    check("armed_busy", 32'(bus.busy), 32'd1);
    check("armed_wait", 32'(bus.wait_led), 32'd1);
    send_byte(8'hEE, '0, 1'b0);
    do_start();
    check("cap_wait", 32'(bus.wait_led), 32'd0);
    do_arm(5'd1);
    send_byte(8'hA5, 4'd0, 1'b1);
    send_byte(8'h3C, 4'd1, 1'b1);
    check("t1_not_done", 32'(bus.done), 32'd0);
    bus.stop_det = 1'b1;
    tick();
    bus.stop_det = 1'b0;
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_status", 32'(bus.status), 32'd0);
    check("t1_count", 32'(bus.byte_count), 32'd2);
    do_ack();
    check("t1_ack_done", 32'(bus.done), 32'd0);
    check("t1_ack_wait", 32'(bus.wait_led), 32'd1);
    check("t1_hold_count", 32'(bus.byte_count), 32'd2);

    // Limit 3, five bytes offered
    do_arm(5'd3);
    check("t2_count_clr", 32'(bus.byte_count), 32'd0);
    do_start();
    send_byte(8'h10, 4'd0, 1'b1);
    send_byte(8'h11, 4'd1, 1'b1);
    send_byte(8'h12, 4'd2, 1'b1);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_status", 32'(bus.status), 32'd1);
    send_byte(8'h13, '0, 1'b0);
    send_byte(8'h14, '0, 1'b0);
    check("t2_count", 32'(bus.byte_count), 32'd3);
    do_ack();

    // Timeout after one byte
    do_arm(5'd16);
    do_start();
    send_byte(8'h55, 4'd0, 1'b1);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    check("t3_not_yet", 32'(bus.done), 32'd0);
    tick();
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_status", 32'(bus.status), 32'd2);
    check("t3_count", 32'(bus.byte_count), 32'd1);
    do_ack();

    // Byte and STOP together below the limit
    do_arm(5'd16);
    do_start();
    send_byte(8'h01, 4'd0, 1'b1);
    bus.stop_det = 1'b1;
    send_byte(8'h77, 4'd1, 1'b1);
    bus.stop_det = 1'b0;
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_status", 32'(bus.status), 32'd0);
    check("t4_count", 32'(bus.byte_count), 32'd2);
    do_ack();

    // Byte and STOP together on the limiting byte
    do_arm(5'd2);
    do_start();
    send_byte(8'h02, 4'd0, 1'b1);
    bus.stop_det = 1'b1;
    send_byte(8'h03, 4'd1, 1'b1);
    bus.stop_det = 1'b0;
    check("t5_status", 32'(bus.status), 32'd1);
    check("t5_count", 32'(bus.byte_count), 32'd2);
    do_ack();

    // Zero limit means full depth
    do_arm(5'd0);
    do_start();
    for (int i = 0; i < 16; i++) begin
      check("t6_not_done", 32'(bus.done), 32'd0);
      send_byte(8'(8'h40 + i), 4'(i), 1'b1);
    end
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_status", 32'(bus.status), 32'd1);
    check("t6_count", 32'(bus.byte_count), 32'd16);
    do_ack();

    // Abort coincident with a byte
    do_arm(5'd16);
    do_start();
    send_byte(8'h22, 4'd0, 1'b1);
    bus.abort = 1'b1;
    send_byte(8'h99, '0, 1'b0);
    bus.abort = 1'b0;
    check("t7_wr_en", 32'(bus.wr_en), 32'd0);
    check("t7_wait", 32'(bus.wait_led), 32'd1);
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_done", 32'(bus.done), 32'd0);
    check("t7_count", 32'(bus.byte_count), 32'd1);
    tick();
    check("t7_idle_busy", 32'(bus.busy), 32'd0);

    // Reset mid-capture, then a normal capture
    do_arm(5'd16);
    do_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hB0 + i), 4'(i), 1'b1);
    rst = 1'b1;
    bus.abort = 1'b1;
    bus.arm = 1'b1;
    send_byte(8'hFF, '0, 1'b0);
    rst = 1'b0;
    bus.abort = 1'b0;
    bus.arm = 1'b0;
    check_reset_vals("t8");
    do_arm(5'd16);
    do_start();
    send_byte(8'hC1, 4'd0, 1'b1);
    send_byte(8'hC2, 4'd1, 1'b1);
    bus.stop_det = 1'b1;
    tick();
    bus.stop_det = 1'b0;
    check("t8_done", 32'(bus.done), 32'd1);
    check("t8_count", 32'(bus.byte_count), 32'd2);
    check("t8_status", 32'(bus.status), 32'd0);

    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
